// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: RV32I load/store width codes, FSM states,
// and the legality and alignment rules for a memory access.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic is_legal(input logic is_load, input logic is_store,
                                    input logic [2:0] f3);
    logic ld_ok;
    logic st_ok;
    ld_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
            (f3 == F3_BU) || (f3 == F3_HU);
    st_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (!is_load || ld_ok) && (!is_store || st_ok);
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return ~addr_lo[0];
      2'b10:   return addr_lo == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
// Purely combinational so the WB bypass path can share it.
module load_align_ext
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'b0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'b0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ready data port, stalls the
// pipeline while an access is outstanding and feeds aligned results to mem_wb.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        stall_req,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;

  logic        mem_op, legal_ok, access, expired;
  logic        req, we, stall, rw, mr, m_err, b_err;
  logic [3:0]  be_raw;
  logic [31:0] ld_data;

  assign mem_op   = valid_in & (mem_read_in | mem_write_in) & ~flush;
  assign legal_ok = is_legal(mem_read_in, mem_write_in, funct3_in) &
                    is_aligned(funct3_in, alu_result_in[1:0]);
  assign access   = mem_op & legal_ok;
  assign expired  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  // The write strobe is captured at issue so a flush cannot alter a transfer in flight
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    we_d    = we_q;
    req     = 1'b0;
    we      = 1'b0;
    stall   = 1'b0;
    m_err   = 1'b0;
    b_err   = 1'b0;
    rw      = valid_in & reg_write_in & ~flush;
    mr      = valid_in & mem_read_in & ~flush;

    case (state_q)
      IDLE: begin
        req   = access;
        we    = mem_write_in & access;
        m_err = mem_op & ~legal_ok;
        if (access && !dmem_ready) begin
          stall   = 1'b1;
          state_d = WAIT;
          we_d    = mem_write_in;
        end
      end
      WAIT: begin
        req   = 1'b1;
        we    = we_q;
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (dmem_ready) begin
          stall   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (expired) begin
          req     = 1'b0;
          we      = 1'b0;
          stall   = 1'b0;
          b_err   = ~flush;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Hold the pipeline through the final cycle so the slot behind is not skipped
        req   = 1'b1;
        we    = we_q;
        stall = 1'b1;
        rw    = 1'b0;
        mr    = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (dmem_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (expired) begin
          req     = 1'b0;
          we      = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (m_err || b_err) rw = 1'b0;
  end

  always_comb begin
    case (funct3_in[1:0])
      2'b00:   be_raw = 4'b0001 << alu_result_in[1:0];
      2'b01:   be_raw = alu_result_in[1] ? 4'b1100 : 4'b0011;
      default: be_raw = 4'b1111;
    endcase
    case (funct3_in[1:0])
      2'b00:   dmem_wdata = {4{store_data_in[7:0]}};
      2'b01:   dmem_wdata = {2{store_data_in[15:0]}};
      default: dmem_wdata = store_data_in;
    endcase
  end

  load_align_ext u_align (
    .rdata   (dmem_rdata),
    .addr_lo (alu_result_in[1:0]),
    .funct3  (funct3_in),
    .data    (ld_data)
  );

  assign dmem_addr      = {alu_result_in[31:2], 2'b00};
  assign dmem_be        = be_raw & {4{req}};
  assign mem_data_out   = mem_read_in ? ld_data : 32'h0;
  assign alu_result_out = alu_result_in;
  assign rd_out         = rd_in;

  assign dmem_req      = req & reset_n;
  assign dmem_we       = we & reset_n;
  assign stall_req     = stall & reset_n;
  assign reg_write_out = rw & reset_n;
  assign mem_read_out  = mr & reset_n;
  assign misalign_err  = m_err & reset_n;
  assign bus_err       = b_err & reset_n;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a behavioural model
// of the load/store rules, the stall protocol, flush drain and timeout.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in, reg_write_in, mem_read_in, mem_write_in, flush;
  logic [31:0] alu_result_in, store_data_in, dmem_rdata;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic        dmem_ready;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_result_out;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out, stall_req, misalign_err, bus_err;

  int errors = 0;
  int checks = 0;

  int          stallCount, earlyBerr, rOp, rLat;
  logic [31:0] rAddr, rData, rRdata;
  logic [2:0]  rF3;
  logic [4:0]  rRd;
  bit          rValid, rFlush, rRw, rMr, rMw, rAcc, rMerr;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .valid_in       (valid_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .funct3_in      (funct3_in),
    .rd_in          (rd_in),
    .reg_write_in   (reg_write_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .flush          (flush),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata),
    .mem_data_out   (mem_data_out),
    .alu_result_out (alu_result_out),
    .rd_out         (rd_out),
    .reg_write_out  (reg_write_out),
    .mem_read_out   (mem_read_out),
    .stall_req      (stall_req),
    .misalign_err   (misalign_err),
    .bus_err        (bus_err)
  );

  function automatic int accessBytes(input logic [2:0] f3);
    case (f3)
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic bit refLegal(input bit isLoad, input bit isStore, input logic [2:0] f3);
    bit ldOk, stOk;
    ldOk = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    stOk = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (!isLoad || ldOk) && (!isStore || stOk);
  endfunction

  function automatic bit refAligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % accessBytes(f3)) == 0;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                          input logic [2:0] f3);
    logic [31:0] b, h;
    b = (rdata >> (8 * (addr % 4))) & 32'hFF;
    h = (rdata >> (8 * (addr % 4))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] refBe(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] m;
    m = ((32'd1 << accessBytes(f3)) - 1) << (addr % 4);
    return m & 32'hF;
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] data);
    case (accessBytes(f3))
      1:       return (data & 32'hFF) * 32'h01010101;
      2:       return (data & 32'hFFFF) * 32'h00010001;
      default: return data;
    endcase
  endfunction

  task automatic applyStimulus(input bit v, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [2:0] f3, input logic [4:0] rd, input bit rw,
                               input bit mr, input bit mw, input bit fl, input bit rdy,
                               input logic [31:0] rdata);
    valid_in      = v;
    alu_result_in = addr;
    store_data_in = sdata;
    funct3_in     = f3;
    rd_in         = rd;
    reg_write_in  = rw;
    mem_read_in   = mr;
    mem_write_in  = mw;
    flush         = fl;
    dmem_ready    = rdy;
    dmem_rdata    = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    applyStimulus(0, 32'h0, 32'h0, 3'd0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    $display("[TB] start");
    reset_n = 1'b0;
    applyStimulus(1, 32'h100, 32'h0, 3'd2, 5'd3, 1, 1, 0, 0, 0, 32'h0);
    #2;
    checkOutput("rst_req", dmem_req, 0);
    checkOutput("rst_stall", stall_req, 0);
    checkOutput("rst_rw", reg_write_out, 0);
    checkOutput("rst_mr", mem_read_out, 0);
    tick();
    tick();
    reset_n = 1'b1;
    bubble();
    tick();

    // LB from the top lane, zero-wait
    applyStimulus(1, 32'h103, 32'h0, 3'd0, 5'd7, 1, 1, 0, 0, 1, 32'h80FF1234);
    #2;
    checkOutput("lb_data", mem_data_out, 32'hFFFFFF80);
    checkOutput("lb_stall", stall_req, 0);
    checkOutput("lb_rw", reg_write_out, 1);
    checkOutput("lb_req", dmem_req, 1);
    checkOutput("lb_addr", dmem_addr, 32'h100);
    checkOutput("lb_rd", rd_out, 7);
    tick();

    // SH to the upper half
    applyStimulus(1, 32'h202, 32'h0000BEEF, 3'd1, 5'd0, 0, 0, 1, 0, 1, 32'h0);
    #2;
    checkOutput("sh_be", dmem_be, 4'b1100);
    checkOutput("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    checkOutput("sh_we", dmem_we, 1);
    checkOutput("sh_stall", stall_req, 0);
    tick();

    // LW with ready on the fourth cycle
    stallCount = 0;
    for (int k = 0; k <= 3; k++) begin
      applyStimulus(1, 32'h204, 32'h0, 3'd2, 5'd4, 1, 1, 0, 0, (k == 3), 32'hCAFEF00D);
      #2;
      if (stall_req) stallCount++;
      checkOutput("lw_req", dmem_req, 1);
      if (k == 3) checkOutput("lw_data", mem_data_out, 32'hCAFEF00D);
      tick();
    end
    checkOutput("lw_stall_cycles", stallCount, 3);
    bubble();
    #2;
    checkOutput("lw_idle_req", dmem_req, 0);
    checkOutput("lw_idle_stall", stall_req, 0);
    tick();

    // Misaligned LW
    applyStimulus(1, 32'h101, 32'h0, 3'd2, 5'd9, 1, 1, 0, 0, 0, 32'h0);
    #2;
    checkOutput("mis_err", misalign_err, 1);
    checkOutput("mis_req", dmem_req, 0);
    checkOutput("mis_rw", reg_write_out, 0);
    checkOutput("mis_stall", stall_req, 0);
    tick();
    bubble();
    #2;
    checkOutput("mis_pulse_end", misalign_err, 0);
    tick();

    // Flush while waiting, ready two cycles after the flush
    applyStimulus(1, 32'h300, 32'h0, 3'd2, 5'd5, 1, 1, 0, 0, 0, 32'h0);
    #2;
    checkOutput("fl_issue_stall", stall_req, 1);
    tick();
    applyStimulus(1, 32'h300, 32'h0, 3'd2, 5'd5, 1, 1, 0, 1, 0, 32'h0);
    #2;
    checkOutput("fl_wait_stall", stall_req, 1);
    checkOutput("fl_wait_rw", reg_write_out, 0);
    tick();
    bubble();
    #2;
    checkOutput("fl_drain_stall", stall_req, 1);
    checkOutput("fl_drain_req", dmem_req, 1);
    tick();
    bubble();
    dmem_ready = 1'b1;
    #2;
    checkOutput("fl_drain_rdy_rw", reg_write_out, 0);
    checkOutput("fl_drain_rdy_req", dmem_req, 1);
    tick();
    bubble();
    #2;
    checkOutput("fl_after_req", dmem_req, 0);
    checkOutput("fl_after_stall", stall_req, 0);
    tick();

    // Timeout with no ready
    earlyBerr = 0;
    applyStimulus(1, 32'h400, 32'h0, 3'd2, 5'd6, 1, 1, 0, 0, 0, 32'h0);
    #2;
    checkOutput("to_issue_stall", stall_req, 1);
    tick();
    for (int w = 1; w <= TIMEOUT; w++) begin
      #2;
      if (w < TIMEOUT) begin
        if (bus_err) earlyBerr++;
      end else begin
        checkOutput("to_berr", bus_err, 1);
        checkOutput("to_req", dmem_req, 0);
        checkOutput("to_stall", stall_req, 0);
        checkOutput("to_rw", reg_write_out, 0);
      end
      tick();
    end
    checkOutput("to_early_berr", earlyBerr, 0);
    bubble();
    #2;
    checkOutput("to_berr_end", bus_err, 0);
    tick();

    // Reset asserted mid-WAIT
    applyStimulus(1, 32'h500, 32'h0, 3'd2, 5'd8, 1, 1, 0, 0, 0, 32'h0);
    tick();
    tick();
    reset_n = 1'b0;
    #2;
    checkOutput("rw_mid_req", dmem_req, 0);
    checkOutput("rw_mid_stall", stall_req, 0);
    tick();
    reset_n = 1'b1;
    applyStimulus(1, 32'h501, 32'h0, 3'd2, 5'd8, 1, 1, 0, 0, 0, 32'h0);
    #2;
    checkOutput("rw_idle_mis", misalign_err, 1);
    checkOutput("rw_idle_req", dmem_req, 0);
    tick();
    bubble();
    tick();

    // Randomized transactions
    for (int t = 0; t < 150; t++) begin
      rOp    = $urandom_range(0, 2);
      rAddr  = $urandom;
      rData  = $urandom;
      rRdata = $urandom;
      rF3    = 3'($urandom_range(0, 7));
      rRd    = 5'($urandom_range(0, 31));
      rValid = ($urandom_range(0, 7) != 0);
      rFlush = ($urandom_range(0, 9) == 0);
      rMr    = (rOp == 0);
      rMw    = (rOp == 1);
      rRw    = (rOp == 0) ? 1'b1 : ((rOp == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      rMerr  = rValid && (rOp != 2) && !rFlush &&
               !(refLegal(rMr, rMw, rF3) && refAligned(rF3, rAddr));
      rAcc   = rValid && (rOp != 2) && !rFlush && !rMerr;
      rLat   = rAcc ? $urandom_range(0, 3) : 0;
      for (int k = 0; k <= rLat; k++) begin
        applyStimulus(rValid, rAddr, rData, rF3, rRd, rRw, rMr, rMw, rFlush,
                      rAcc && (k == rLat), rRdata);
        #2;
        checkOutput("rnd_req", dmem_req, rAcc);
        checkOutput("rnd_stall", stall_req, rAcc && (k < rLat));
        checkOutput("rnd_mis", misalign_err, rMerr);
        checkOutput("rnd_berr", bus_err, 0);
        checkOutput("rnd_rw", reg_write_out, rValid && rRw && !rFlush && !rMerr);
        checkOutput("rnd_mr", mem_read_out, rValid && rMr && !rFlush);
        if (rAcc) begin
          checkOutput("rnd_we", dmem_we, rMw);
          checkOutput("rnd_addr", dmem_addr, rAddr & 32'hFFFFFFFC);
          if (rMw) begin
            checkOutput("rnd_be", dmem_be, refBe(rF3, rAddr));
            checkOutput("rnd_wdata", dmem_wdata, refWdata(rF3, rData));
          end
          if (rMr && k == rLat) checkOutput("rnd_ldata", mem_data_out, refLoad(rRdata, rAddr, rF3));
        end
        if (rOp == 2) checkOutput("rnd_nonload", mem_data_out, 0);
        if (k == 0) begin
          checkOutput("rnd_rd", rd_out, rRd);
          checkOutput("rnd_alu", alu_result_out, rAddr);
        end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM pipeline stage sitting between the EX/MEM register and the MEM/WB register (mem_wb).
- Issues loads and stores to a data-memory port with a req/ready handshake and generates byte enables.
- Aligns and sign/zero-extends load data.
- Requests a pipeline stall while a memory access is outstanding.
- Drives mem_wb's mem_data_in, alu_result_in, rd_in, reg_write_in and mem_read_in.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before bus error; 0 disables timeout
CNT_W, 5, width of the wait counter; must hold TIMEOUT

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  EX/MEM slot holds a live instruction
alu_result_in  in  32  effective address / ALU result
store_data_in  in  32  rs2 value for stores
funct3_in  in  3  RV32I load/store width code
rd_in  in  5  destination register
reg_write_in, mem_read_in, mem_write_in  in  1 each  control bits
flush  in  1  kill current instruction
dmem_req, dmem_we  out  1 each  request / write strobe
dmem_addr  out  32  word-aligned address {alu_result_in[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  access complete this cycle (rdata valid for loads)
dmem_rdata  in  32  read word
mem_data_out  out  32  aligned/extended load data to mem_wb
alu_result_out  out  32  pass-through of alu_result_in
rd_out  out  5  pass-through of rd_in
reg_write_out, mem_read_out  out  1 each  qualified control to mem_wb
stall_req  out  1  hold IF..EX/MEM and stall mem_wb
misalign_err, bus_err  out  1 each  one-cycle exception pulses

Behaviour:
- access = valid_in & (mem_read_in | mem_write_in) & !flush & aligned & legal funct3.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
- Aligned: halfword requires addr[0]=0; word requires addr[1:0]=0.
- FSM states IDLE, WAIT, DRAIN; the state register and wait counter reset asynchronously to IDLE/0.
- While reset_n=0, force to 0: dmem_req, dmem_we, stall_req, reg_write_out, mem_read_out, misalign_err, bus_err.
- IDLE:
  - dmem_req=access, combinational from inputs.
  - If dmem_ready is high in the same cycle: zero-wait completion, no stall, stay in IDLE.
  - Otherwise, if access: stall_req=1 and go to WAIT.
- WAIT:
  - dmem_req held, stall_req=1, counter increments each cycle. Upstream keeps its inputs stable.
  - dmem_ready: complete, stall_req=0 in that cycle, return to IDLE at the next edge.
  - flush without dmem_ready: go to DRAIN.
  - Counter reaches TIMEOUT-1 without ready: pulse bus_err, drop req, stall_req=0, reg_write_out=0, return to IDLE.
- DRAIN:
  - dmem_req held (a bus transfer cannot be aborted), stall_req=1.
  - On dmem_ready: discard data, return to IDLE. No new request issues from DRAIN.
  - DRAIN is subject to the same timeout; on expiry return to IDLE without asserting bus_err.
- Stores:
  - SB: be=0001<<addr[1:0], wdata={4{b}}.
  - SH: be=0011<<(2*addr[1]), wdata={2{h}}.
  - SW: be=1111.
  - dmem_we=mem_write_in & access.
- Loads:
  - Select the byte/half lane by addr[1:0] from dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - mem_data_out is 0 for non-loads.
- Misaligned or illegal access with valid_in and !flush:
  - misalign_err=1, no dmem_req, reg_write_out=0, no stall.
- reg_write_out = valid_in & reg_write_in & !flush & !misalign_err & !bus_err.
- mem_read_out = valid_in & mem_read_in & !flush.
- A new request is never issued in the same cycle a WAIT completion occurs; it issues from IDLE on the next cycle.

Decomposition:
- Shared package holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2.
- One natural sub-module: load_align_ext, combinational: rdata, addr[1:0], funct3 -> 32-bit data. It is reused by the WB bypass path.

Test Plan:
- LB at addr 0x103, rdata 0x80FF1234, zero-wait ready -> mem_data_out 0xFFFFFF80, stall_req never 1, reg_write_out=1.
- SH at addr 0x202, store_data 0x0000BEEF -> dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1.
- LW with ready after 3 cycles -> stall_req high exactly 3 cycles, mem_data_out=rdata in the completion cycle, state back to IDLE.
- LW at addr 0x101 -> misalign_err pulses 1 cycle, dmem_req=0, reg_write_out=0.
- flush during WAIT, ready 2 cycles later -> DRAIN, stall_req held until ready, reg_write_out=0, no second request.
- No ready for TIMEOUT=16 cycles -> bus_err pulses in the 16th WAIT cycle, req dropped; reset_n asserted mid-WAIT -> IDLE immediately, dmem_req=0.
